// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pipe
//  Purpose  : Parametrised 3-stage floating-point multiplier with valid/ready
//             handshake. Round-to-nearest-even, denormals-are-zero, flush to
//             zero on underflow, canonical quiet NaN, per-result flags.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   operands accepted this cycle
//   in_a/in_b  in   W   operands {sign, exp, frac}, W = 1+EXP_W+FRAC_W
//   out_valid  out  1   product valid
//   out_ready  in   1   downstream accepts product
//   out_p      out  W   product
//   out_flags  out  4   {invalid, overflow, underflow, inexact}
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_p,
  output logic [3:0]              out_flags
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;      // significand width with hidden bit
  localparam int EW = EXP_W + 2;       // signed working exponent width

  localparam logic [EW-1:0]    BIAS_E   = EW'(BIAS);
  localparam logic [EW-1:0]    EMAX_E   = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  // Special-case result selected in S1, applied at packing time in S3.
  typedef enum logic [2:0] {
    SPC_NONE = 3'd0,
    SPC_QNAN = 3'd1,
    SPC_INV  = 3'd2,
    SPC_INF  = 3'd3,
    SPC_ZERO = 3'd4
  } spc_t;

  // Whole pipeline advances together; it only freezes when the output
  // register holds a result nobody is taking.
  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;

  logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  // exp==0 covers both true zero and denormals (treated as zero).
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == EXP_ONES) & (fa != '0);
  assign b_nan  = (eb == EXP_ONES) & (fb != '0);
  assign a_inf  = (ea == EXP_ONES) & (fa == '0);
  assign b_inf  = (eb == EXP_ONES) & (fb == '0);

  spc_t spc1;
  always_comb begin
    spc1 = SPC_NONE;
    if (a_nan | b_nan)                          spc1 = SPC_QNAN;
    else if ((a_inf & b_zero) | (b_inf & a_zero)) spc1 = SPC_INV;
    else if (a_inf | b_inf)                     spc1 = SPC_INF;
    else if (a_zero | b_zero)                   spc1 = SPC_ZERO;
  end

  logic [2*M-1:0] prod1;
  logic [EW-1:0]  esum1;
  assign prod1 = {{M{1'b0}}, 1'b1, fa} * {{M{1'b0}}, 1'b1, fb};
  assign esum1 = {2'b00, ea} + {2'b00, eb} - BIAS_E;

  logic           s1_valid, s1_sign;
  logic [EW-1:0]  s1_exp;
  logic [2*M-1:0] s1_prod;
  spc_t           s1_spc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
      s1_spc   <= SPC_NONE;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_exp   <= esum1;
      s1_prod  <= prod1;
      s1_spc   <= spc1;
    end
  end

  // ---------------------------------------------------------------- S2
  // Product of two [1,2) significands lies in [1,4): MSB set means >= 2.
  logic          norm, guard, sticky, rnd_up, carry;
  logic [M-1:0]  mant;
  logic [M:0]    mant_r;
  logic [EW-1:0] exp2;
  logic [FRAC_W-1:0] frac2;

  assign norm = s1_prod[2*M-1];

  always_comb begin
    if (norm) begin
      mant   = s1_prod[2*M-1:M];
      guard  = s1_prod[M-1];
      sticky = |s1_prod[M-2:0];
    end else begin
      mant   = s1_prod[2*M-2:M-1];
      guard  = s1_prod[M-2];
      sticky = |s1_prod[M-3:0];
    end
  end

  assign rnd_up = guard & (sticky | mant[0]);
  assign mant_r = {1'b0, mant} + {{M{1'b0}}, rnd_up};
  assign carry  = mant_r[M];
  // A rounding carry turns 1.11..1 into 10.00..0: shift right once.
  assign frac2  = carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
  assign exp2   = s1_exp + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, carry};

  logic              s2_valid, s2_sign, s2_inexact;
  logic [EW-1:0]     s2_exp;
  logic [FRAC_W-1:0] s2_frac;
  spc_t              s2_spc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_inexact <= 1'b0;
      s2_exp     <= '0;
      s2_frac    <= '0;
      s2_spc     <= SPC_NONE;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_inexact <= guard | sticky;
      s2_exp     <= exp2;
      s2_frac    <= frac2;
      s2_spc     <= s1_spc;
    end
  end

  // ---------------------------------------------------------------- S3
  logic         ovf, unf;
  logic [W-1:0] p3;
  logic [3:0]   f3;

  assign ovf = ~s2_exp[EW-1] & (s2_exp >= EMAX_E);
  assign unf =  s2_exp[EW-1] | (s2_exp == '0);

  always_comb begin
    p3 = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    f3 = {3'b000, s2_inexact};
    case (s2_spc)
      SPC_QNAN: begin p3 = QNAN;                              f3 = 4'b0000; end
      SPC_INV:  begin p3 = QNAN;                              f3 = 4'b1000; end
      SPC_INF:  begin p3 = {s2_sign, EXP_ONES, {FRAC_W{1'b0}}}; f3 = 4'b0000; end
      SPC_ZERO: begin p3 = {s2_sign, {(W-1){1'b0}}};          f3 = 4'b0000; end
      default: begin
        if (ovf) begin
          p3 = {s2_sign, EXP_ONES, {FRAC_W{1'b0}}};
          f3 = 4'b0101;
        end else if (unf) begin
          p3 = {s2_sign, {(W-1){1'b0}}};
          f3 = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p     <= p3;
        out_flags <= f3;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_pipe
//  Purpose  : Self-checking bench for fp_mul_pipe (binary32 and binary16
//             instances). Expected results are queued on acceptance and a
//             monitor compares every presented output against the queue head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // binary32 instance
  logic        iv32 = 0, ir32, ov32, or32 = 1;
  logic [31:0] a32 = 0, b32 = 0, op32;
  logic [3:0]  of32;
  // binary16 instance
  logic        iv16 = 0, ir16, ov16, or16 = 1;
  logic [15:0] a16 = 0, b16 = 0, op16;
  logic [3:0]  of16;

  fp_mul_pipe dut32 (
    .clk(clk), .rstn(rstn),
    .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .out_valid(ov32), .out_ready(or32), .out_p(op32), .out_flags(of32)
  );

  fp_mul_pipe #(.EXP_W(5), .FRAC_W(10)) dut16 (
    .clk(clk), .rstn(rstn),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(or16), .out_p(op16), .out_flags(of16)
  );

  typedef struct packed { logic [31:0] p; logic [3:0] f; } exp_t;
  exp_t q32[$];
  exp_t q16[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit d32 = 0, d16 = 0;

  // {a, b, expected p, expected flags}
  localparam logic [99:0] V32 [10] = '{
    {32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0},
    {32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0},
    {32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1},
    {32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5},
    {32'h00800000, 32'h00800000, 32'h00000000, 4'h3},
    {32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8},
    {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0},
    {32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0},
    {32'h00000001, 32'h3F800000, 32'h00000000, 4'h0},
    {32'h80400000, 32'h3F800000, 32'h80000000, 4'h0}
  };
  localparam logic [99:0] V16 [8] = '{
    {32'h3E00, 32'h4000, 32'h4200, 4'h0},
    {32'hBC00, 32'h4200, 32'hC200, 4'h0},
    {32'h3C01, 32'h3C01, 32'h3C02, 4'h1},
    {32'h7800, 32'h7800, 32'h7C00, 4'h5},
    {32'h0400, 32'h0400, 32'h0000, 4'h3},
    {32'h7C00, 32'h0000, 32'h7E00, 4'h8},
    {32'h7E01, 32'h3C00, 32'h7E00, 4'h0},
    {32'hFC00, 32'h4000, 32'hFC00, 4'h0}
  };

  // Reference: exact integer product, remainder-based RNE, then range rules.
  function automatic void ref_mul(input int ew, input int fw,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic [3:0] f);
    longint one, emax, bias, ea, eb, fa, fb, sgn, prod, q, r, half, e, sh;
    longint inf_v, zero_v, qnan_v, res;
    bit an, bn, ai, bi, az, bz;
    one  = 1;
    emax = (one << ew) - 1;
    bias = (one << (ew - 1)) - 1;
    ea = (longint'(a) >> fw) & emax;
    eb = (longint'(b) >> fw) & emax;
    fa = longint'(a) & ((one << fw) - 1);
    fb = longint'(b) & ((one << fw) - 1);
    sgn = ((longint'(a) >> (ew + fw)) ^ (longint'(b) >> (ew + fw))) & 1;
    an = (ea == emax) && (fa != 0);  bn = (eb == emax) && (fb != 0);
    ai = (ea == emax) && (fa == 0);  bi = (eb == emax) && (fb == 0);
    az = (ea == 0);                  bz = (eb == 0);
    zero_v = sgn << (ew + fw);
    inf_v  = zero_v | (emax << fw);
    qnan_v = (emax << fw) | (one << (fw - 1));
    f = 4'h0;
    if (an || bn)                    res = qnan_v;
    else if ((ai && bz) || (bi && az)) begin res = qnan_v; f = 4'h8; end
    else if (ai || bi)               res = inf_v;
    else if (az || bz)               res = zero_v;
    else begin
      prod = (fa | (one << fw)) * (fb | (one << fw));
      sh   = (prod >= (one << (2 * fw + 1))) ? fw + 1 : fw;
      q    = prod >> sh;
      r    = prod - (q << sh);
      half = one << (sh - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
      e = ea + eb - bias + (sh - fw);
      if (q == (one << (fw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= emax)    begin res = inf_v;  f = 4'h5; end
      else if (e <= 0)  begin res = zero_v; f = 4'h3; end
      else begin
        res = zero_v | (e << fw) | (q - (one << fw));
        f   = (r != 0) ? 4'h1 : 4'h0;
      end
    end
    p = res[31:0];
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int fw);
    int emax, bias;
    logic [31:0] s, e, f;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s = $urandom % 2;
    case ($urandom % 8)
      0:       e = 0;
      1:       e = 32'(emax);
      2, 3, 4: e = 32'(bias - 4) + ($urandom % 9);
      default: e = 1 + ($urandom % 32'(emax - 1));
    endcase
    f = $urandom & ((32'd1 << fw) - 1);
    case ($urandom % 6)
      0:       f = 0;
      1:       f = (32'd1 << fw) - 1;
      default: ;
    endcase
    return (s << (ew + fw)) | (e << fw) | f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ep, input logic [3:0] ef);
    exp_t e;
    e.p = ep;
    e.f = ef;
    if (sel == 0) begin iv32 = 1; a32 = a; b32 = b; end
    else          begin iv16 = 1; a16 = a[15:0]; b16 = b[15:0]; end
    for (int t = 0; t < 200; t++) begin
      #1;
      if ((sel == 0 && ir32) || (sel == 1 && ir16)) begin
        if (sel == 0) q32.push_back(e); else q16.push_back(e);
        @(negedge clk);
        if (sel == 0) iv32 = 0; else iv16 = 0;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready low for 200 cycles, expected acceptance (sel %0d)", sel);
    if (sel == 0) iv32 = 0; else iv16 = 0;
  endtask

  task automatic send_rand(input int sel, input bit gaps);
    logic [31:0] a, b, p;
    logic [3:0]  f;
    if (gaps && ($urandom % 4 == 0)) @(negedge clk);
    if (sel == 0) begin
      a = rand_op(8, 23);  b = rand_op(8, 23);  ref_mul(8, 23, a, b, p, f);
    end else begin
      a = rand_op(5, 10);  b = rand_op(5, 10);  ref_mul(5, 10, a, b, p, f);
    end
    send(sel, a, b, p, f);
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (q32.size() == 0 && q16.size() == 0) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d/%0d results outstanding, expected 0/0", q32.size(), q16.size());
    q32.delete();
    q16.delete();
  endtask

  // Monitors: sample after inputs for the coming edge have settled. The head
  // of the queue is compared on every presented cycle, including stalls.
  always begin
    @(negedge clk);
    #2;
    if (rstn && ov32) begin
      n_cmp++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL out32_unexpected: got p=%h flags=%h, expected no output", op32, of32);
      end else if (op32 !== q32[0].p || of32 !== q32[0].f) begin
        n_fail++;
        $display("FAIL out32: got p=%h flags=%h, expected p=%h flags=%h",
                 op32, of32, q32[0].p, q32[0].f);
      end
      if (or32 && q32.size() != 0) void'(q32.pop_front());
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rstn && ov16) begin
      n_cmp++;
      if (q16.size() == 0) begin
        n_fail++;
        $display("FAIL out16_unexpected: got p=%h flags=%h, expected no output", op16, of16);
      end else if (op16 !== q16[0].p[15:0] || of16 !== q16[0].f) begin
        n_fail++;
        $display("FAIL out16: got p=%h flags=%h, expected p=%h flags=%h",
                 op16, of16, q16[0].p[15:0], q16[0].f);
      end
      if (or16 && q16.size() != 0) void'(q16.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [99:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid32", {31'b0, ov32}, 32'd0);
    chk("rst_out_p32", op32, 32'd0);
    chk("rst_out_flags32", {28'b0, of32}, 32'd0);
    chk("rst_out_valid16", {31'b0, ov16}, 32'd0);
    rstn = 1;
    #1;
    chk("rst_in_ready32", {31'b0, ir32}, 32'd1);
    @(negedge clk);

    // Latency: presented at N0, out_valid visible at N3
    v = V32[0];
    send(0, v[99:68], v[67:36], v[35:4], v[3:0]);
    #1 chk("lat_n1", {31'b0, ov32}, 32'd0);
    @(negedge clk); #1 chk("lat_n2", {31'b0, ov32}, 32'd0);
    @(negedge clk); #1 chk("lat_n3", {31'b0, ov32}, 32'd1);
    @(negedge clk);

    // Directed arithmetic and special values
    for (int i = 1; i < 10; i++) begin
      v = V32[i];
      send(0, v[99:68], v[67:36], v[35:4], v[3:0]);
    end
    for (int i = 0; i < 8; i++) begin
      v = V16[i];
      send(1, v[99:68], v[67:36], v[35:4], v[3:0]);
    end
    drain();

    // Backpressure: 8 back-to-back ops, out_ready low for 5 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        or32 = 0;
        repeat (2) @(negedge clk);
        #1 chk("stall_in_ready32", {31'b0, ir32}, 32'd0);
        repeat (3) @(negedge clk);
        or32 = 1;
      end
    join
    drain();

    // Randomised traffic with random backpressure on both instances
    d32 = 0;
    d16 = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) send_rand(0, 1'b1);
        d32 = 1;
      end
      begin
        for (int i = 0; i < 150; i++) send_rand(1, 1'b1);
        d16 = 1;
      end
      begin
        while (!(d32 && d16)) begin
          @(negedge clk);
          or32 = ($urandom % 4) != 0;
          or16 = ($urandom % 4) != 0;
        end
        or32 = 1;
        or16 = 1;
      end
    join
    drain();

    // Reset with three operations in flight
    or32 = 0;
    for (int i = 0; i < 3; i++) send_rand(0, 1'b0);
    rstn = 0;
    #1;
    chk("midrst_out_valid32", {31'b0, ov32}, 32'd0);
    chk("midrst_out_p32", op32, 32'd0);
    chk("midrst_in_ready32", {31'b0, ir32}, 32'd1);
    q32.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    or32 = 1;
    v = V32[1];
    send(0, v[99:68], v[67:36], v[35:4], v[3:0]);
    drain();
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
